// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel registered stream mux, fixed-select or round-robin arbitration.
// Define STREAM_MUX_LOCK_EN to add in_last/out_last and hold the grant until a packet's last beat.
module stream_mux_arb #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [NCH-1:0]       in_last,
  output logic                 out_last,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  logic             load_en;
  logic             gany;
  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  gidx;
  logic [SELW-1:0]  cidx;
  logic [SELW-1:0]  ptr;
  logic [WIDTH-1:0] gdata;

`ifdef STREAM_MUX_LOCK_EN
  typedef enum logic {ARB_FREE, ARB_LOCKED} lock_t;
  lock_t           lock_state, lock_next;
  logic [SELW-1:0] lock_ch, lock_ch_next;
`endif

  assign load_en  = !out_valid || out_ready;
  assign in_ready = load_en ? grant : '0;

  always_comb begin
    gany = 1'b0;
    gidx = '0;
    cidx = '0;
`ifdef STREAM_MUX_LOCK_EN
    if (lock_state == ARB_LOCKED) begin
      gany = in_valid[lock_ch];
      gidx = lock_ch;
    end else
`endif
    if (!mode) begin
      if (32'(sel) < NCH) begin
        gany = in_valid[sel];
        gidx = sel;
      end
    end else begin
      // Scan ptr+1 .. ptr+NCH modulo NCH; the first valid channel wins.
      for (int unsigned o = 1; o <= NCH; o++) begin
        cidx = SELW'((32'(ptr) + o) % NCH);
        if (!gany && in_valid[cidx]) begin
          gany = 1'b1;
          gidx = cidx;
        end
      end
    end
    grant       = '0;
    grant[gidx] = gany;
    gdata       = in_data[gidx*WIDTH +: WIDTH];
  end

`ifdef STREAM_MUX_LOCK_EN
  always_comb begin
    lock_next    = lock_state;
    lock_ch_next = lock_ch;
    if (load_en && gany) begin
      lock_ch_next = gidx;
      lock_next    = in_last[gidx] ? ARB_FREE : ARB_LOCKED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= ARB_FREE;
      lock_ch    <= '0;
    end else begin
      lock_state <= lock_next;
      lock_ch    <= lock_ch_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SELW'(NCH - 1);
`ifdef STREAM_MUX_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (load_en) begin
      if (gany) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_chan  <= gidx;
`ifdef STREAM_MUX_LOCK_EN
        out_last  <= in_last[gidx];
`endif
        if (mode) begin
          ptr <= gidx;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: table-driven vectors with an output scoreboard,
// plus hand sequences for reset mid-stall, out-of-range select and packet lock.
module tb_stream_mux_arb;
  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 16;
  localparam int unsigned SW  = 2;
`ifdef STREAM_MUX_LOCK_EN
  localparam bit LOCKB = 1'b1;
`else
  localparam bit LOCKB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic [SW-1:0]    sel;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SW-1:0]    out_chan;
`ifdef STREAM_MUX_LOCK_EN
  logic [NCH-1:0]   in_last;
  logic             out_last;
`endif

  // Second instance with NCH=5 so that sel can exceed the channel count.
  logic          m5_mode;
  logic [2:0]    m5_sel;
  logic [5*W-1:0] m5_data;
  logic [4:0]    m5_valid;
  logic [4:0]    m5_ready;
  logic [W-1:0]  m5_odata;
  logic          m5_ovalid;
  logic          m5_ordy;
  logic [2:0]    m5_chan;
`ifdef STREAM_MUX_LOCK_EN
  logic [4:0]    m5_last;
  logic          m5_olast;
`endif

  always #5 clk = ~clk;

  stream_mux_arb #(.NCH(NCH), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan)
  );

  stream_mux_arb #(.NCH(5), .WIDTH(W)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(m5_mode), .sel(m5_sel),
    .in_data(m5_data), .in_valid(m5_valid), .in_ready(m5_ready),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(m5_last), .out_last(m5_olast),
`endif
    .out_data(m5_odata), .out_valid(m5_ovalid), .out_ready(m5_ordy),
    .out_chan(m5_chan)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] chan;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic           mode;
    logic [SW-1:0]  sel;
    logic [NCH-1:0] iv;
    logic           ordy;
    logic [NCH-1:0] exp_rdy;
  } vec_t;

  beat_t sb[$];
  vec_t  vt[24];
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCH*W-1:0] mkdata(input int unsigned tag);
    logic [NCH*W-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      d[i*W +: W] = W'(32'hA000 + tag * 16 + i);
    end
    return d;
  endfunction

  // Drives one cycle, checks the combinational ready and the output register
  // against the scoreboard, then advances past the next rising edge.
  task automatic step(input logic m, input logic [SW-1:0] s, input logic [NCH-1:0] iv,
                      input logic [NCH-1:0] il, input logic ordy,
                      input logic [NCH-1:0] exp_rdy, input logic [NCH*W-1:0] d);
    beat_t b;
    mode      = m;
    sel       = s;
    in_valid  = iv;
    out_ready = ordy;
    in_data   = d;
`ifdef STREAM_MUX_LOCK_EN
    in_last   = il;
`endif
    #4;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_data", 64'(out_data), 64'(sb[0].data));
      check("out_chan", 64'(out_chan), 64'(sb[0].chan));
`ifdef STREAM_MUX_LOCK_EN
      check("out_last", 64'(out_last), 64'(sb[0].last));
`endif
      if (ordy) void'(sb.pop_front());
    end
    if (exp_rdy != '0) begin
      b = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (exp_rdy[i]) begin
          b.data = d[i*W +: W];
          b.chan = SW'(i);
          b.last = LOCKB & il[i];
        end
      end
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    m5_mode = 1'b0; m5_sel = '0; m5_data = '0; m5_valid = '0; m5_ordy = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
    in_last = '1;
    m5_last = '1;
`endif

    //            mode  sel    iv       ordy  exp_rdy
    vt[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
    vt[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vt[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    vt[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
    vt[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
    vt[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vt[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    vt[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000};
    vt[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010};
    vt[9]  = '{1'b1, 2'd0, 4'b1010, 1'b0, 4'b0000};
    vt[10] = '{1'b1, 2'd0, 4'b1010, 1'b0, 4'b0000};
    vt[11] = '{1'b1, 2'd0, 4'b1010, 1'b0, 4'b0000};
    vt[12] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000};
    vt[13] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000};
    vt[14] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000};
    vt[15] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001};
    vt[16] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vt[17] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vt[18] = '{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0010};
    vt[19] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000};
    vt[20] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000};
    vt[21] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vt[22] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
    vt[23] = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000};

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset out_data", 64'(out_data), 64'(0));
    check("reset out_chan", 64'(out_chan), 64'(0));
`ifdef STREAM_MUX_LOCK_EN
    check("reset out_last", 64'(out_last), 64'(0));
`endif
    rst_n = 1'b1;

    for (int unsigned r = 0; r < 24; r++) begin
      step(vt[r].mode, vt[r].sel, vt[r].iv, '1, vt[r].ordy, vt[r].exp_rdy, mkdata(r));
    end

    // Reset while a beat is stalled in the output register.
    step(1'b1, 2'd0, 4'b0100, '1, 1'b1, 4'b0100, mkdata(30));
    out_ready = 1'b0;
    in_valid  = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'(0));
    check("async rst out_data", 64'(out_data), 64'(0));
    check("async rst out_chan", 64'(out_chan), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 2'd0, 4'b1111, '1, 1'b1, 4'b0001, mkdata(31));
    step(1'b0, 2'd0, 4'b0000, '1, 1'b1, 4'b0000, mkdata(32));

`ifdef STREAM_MUX_LOCK_EN
    // Packet lock: channel 1 keeps the grant across mode/sel changes until its last beat.
    step(1'b1, 2'd0, 4'b0111, 4'b0000, 1'b1, 4'b0010, mkdata(40));
    step(1'b0, 2'd0, 4'b0111, 4'b0000, 1'b1, 4'b0010, mkdata(41));
    step(1'b1, 2'd0, 4'b0111, 4'b0010, 1'b1, 4'b0010, mkdata(42));
    step(1'b1, 2'd0, 4'b0111, 4'b0000, 1'b1, 4'b0100, mkdata(43));
    step(1'b1, 2'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, mkdata(44));
    step(1'b1, 2'd0, 4'b0111, 4'b0100, 1'b1, 4'b0100, mkdata(45));
    step(1'b1, 2'd0, 4'b0000, 4'b1111, 1'b1, 4'b0000, mkdata(46));
`endif

    // Out-of-range select on the five-channel instance.
    m5_data = '0;
    for (int unsigned i = 0; i < 5; i++) m5_data[i*W +: W] = W'(32'h5500 + i);
    m5_mode = 1'b0; m5_sel = 3'd0; m5_valid = 5'b11111; m5_ordy = 1'b1;
    #4;
    check("m5 in_ready sel0", 64'(m5_ready), 64'(5'b00001));
    @(posedge clk);
    #1;
    m5_sel = 3'd5;
    #4;
    check("m5 in_ready sel5", 64'(m5_ready), 64'(0));
    check("m5 out_valid", 64'(m5_ovalid), 64'(1));
    check("m5 out_chan", 64'(m5_chan), 64'(0));
    check("m5 out_data", 64'(m5_odata), 64'(16'h5500));
`ifdef STREAM_MUX_LOCK_EN
    check("m5 out_last", 64'(m5_olast), 64'(1));
`endif
    @(posedge clk);
    #1;
    m5_sel = 3'd7;
    #4;
    check("m5 in_ready sel7", 64'(m5_ready), 64'(0));
    check("m5 out_valid drained", 64'(m5_ovalid), 64'(0));
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
